can_crc_engine: RTL and testbench

Parametrised bit-serial CRC generator/checker for the CAN receive and transmit paths. It accumulates a configurable-length data field, then absorbs the received CRC field into the same LFSR. At frame end it reports a registered pass/fail result and a one-cycle done pulse. It sits after the bit de-stuffer, runs on the system clock, and takes bits through a valid-qualified strobe instead of clocking on the bit strobe itself.

---
 rtl/can_crc_engine.sv | 140 ++++++++++++++
 tb/tb_can_crc_engine.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/can_crc_engine.sv
// Bit-serial CAN CRC generator/checker: absorbs a data field and then the
// received CRC field into one LFSR, and flags a nonzero residue at frame end.
//
// state | meaning
// IDLE  | waiting for i_Start, bits ignored
// DATA  | shifting data bits, cnt = data bits still expected
// CRC   | shifting received CRC bits, cnt = CRC bits still expected
// DONE  | one-cycle frame-end pulse, result already registered
module can_crc_engine #(
   parameter int                   CRC_WIDTH = 15,
   parameter logic [CRC_WIDTH-1:0] CRC_POLY  = 15'h4599,
   parameter logic [CRC_WIDTH-1:0] CRC_INIT  = '0,
   parameter int                   LEN_WIDTH = 7
) (
   input  logic                 i_Clk,
   input  logic                 i_Rst,
   input  logic                 i_Start,
   input  logic [LEN_WIDTH-1:0] i_Len,
   input  logic                 i_Abort,
   input  logic                 i_Bit,
   input  logic                 i_Bit_Valid,
   input  logic                 i_Bit_Stuffed,
   output logic [CRC_WIDTH-1:0] o_CRC,
   output logic                 o_Busy,
   output logic                 o_In_CRC,
   output logic                 o_Done,
   output logic                 o_CRC_Err
);

   if (CRC_WIDTH > (2 ** LEN_WIDTH) - 1) begin : g_len_chk
      $error("can_crc_engine: CRC_WIDTH does not fit in the LEN_WIDTH bit counter");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_CRC  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [LEN_WIDTH-1:0] CNT_CRC = LEN_WIDTH'(CRC_WIDTH);
   localparam logic [LEN_WIDTH-1:0] CNT_ONE = LEN_WIDTH'(1);

   state_t               state_q, state_d;
   logic [CRC_WIDTH-1:0] crc_q, crc_d;
   logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
   logic                 err_q, err_d;

   logic                 accept;
   logic                 inv;
   logic [CRC_WIDTH-1:0] crc_step;

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state_q <= ST_IDLE;
         crc_q   <= CRC_INIT;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         crc_q   <= crc_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign accept   = i_Bit_Valid & ~i_Bit_Stuffed &
                     ((state_q == ST_DATA) | (state_q == ST_CRC));
   assign inv      = i_Bit ^ crc_q[CRC_WIDTH-1];
   assign crc_step = {crc_q[CRC_WIDTH-2:0], 1'b0} ^ (inv ? CRC_POLY : '0);

   always_comb begin
      state_d = state_q;
      crc_d   = crc_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      if (i_Abort) begin
         state_d = ST_IDLE;
         crc_d   = CRC_INIT;
         cnt_d   = '0;
      end else if (i_Start) begin
         crc_d = CRC_INIT;
         err_d = 1'b0;
         if (i_Len == '0) begin
            state_d = ST_CRC;
            cnt_d   = CNT_CRC;
         end else begin
            state_d = ST_DATA;
            cnt_d   = i_Len;
         end
      end else begin
         case (state_q)
            ST_DATA: begin
               if (accept) begin
                  crc_d = crc_step;
                  if (cnt_q == CNT_ONE) begin
                     state_d = ST_CRC;
                     cnt_d   = CNT_CRC;
                  end else if (cnt_q != '0) begin
                     cnt_d = cnt_q - CNT_ONE;
                  end
               end
            end
            ST_CRC: begin
               if (accept) begin
                  crc_d = crc_step;
                  if (cnt_q == CNT_ONE) begin
                     state_d = ST_DONE;
                     cnt_d   = '0;
                     err_d   = (crc_step != '0);
                  end else if (cnt_q != '0) begin
                     cnt_d = cnt_q - CNT_ONE;
                  end
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      o_Busy    = 1'b0;
      o_In_CRC  = 1'b0;
      o_Done    = 1'b0;
      case (state_q)
         ST_DATA: o_Busy = 1'b1;
         ST_CRC: begin
            o_Busy   = 1'b1;
            o_In_CRC = 1'b1;
         end
         ST_DONE: o_Done = 1'b1;
         default: ;
      endcase
   end

   assign o_CRC     = crc_q;
   assign o_CRC_Err = err_q;

endmodule

// File: tb/tb_can_crc_engine.sv
// Bench for can_crc_engine: a frame-level model computes the CRC by polynomial
// long division over the accepted bits and is compared every cycle.
module tb_can_crc_engine;

   localparam int          W    = 15;
   localparam logic [14:0] POLY = 15'h4599;

   logic        i_Clk = 1'b0;
   logic        i_Rst = 1'b1;
   logic        i_Start = 1'b0;
   logic [6:0]  i_Len = '0;
   logic        i_Abort = 1'b0;
   logic        i_Bit = 1'b0;
   logic        i_Bit_Valid = 1'b0;
   logic        i_Bit_Stuffed = 1'b0;
   logic [14:0] o_CRC;
   logic        o_Busy, o_In_CRC, o_Done, o_CRC_Err;

   int checks = 0;
   int failures = 0;
   int done_seen = 0;

   can_crc_engine dut (
      .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Start(i_Start), .i_Len(i_Len),
      .i_Abort(i_Abort), .i_Bit(i_Bit), .i_Bit_Valid(i_Bit_Valid),
      .i_Bit_Stuffed(i_Bit_Stuffed), .o_CRC(o_CRC), .o_Busy(o_Busy),
      .o_In_CRC(o_In_CRC), .o_Done(o_Done), .o_CRC_Err(o_CRC_Err)
   );

   always #5 i_Clk = ~i_Clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Remainder of M(x)*x^W mod G(x), by long division on the bit sequence.
   function automatic logic [14:0] crc_of(input bit q[$]);
      logic [15:0] r;
      bit          msg[$];
      r   = '0;
      msg = q;
      for (int i = 0; i < W; i++) msg.push_back(1'b0);
      foreach (msg[i]) begin
         r = {r[14:0], msg[i]};
         if (r[15]) r = r ^ {1'b1, POLY};
      end
      return r[14:0];
   endfunction

   // Frame-level model: phase 0 idle, 1 data, 2 crc field, 3 done.
   int  m_phase;
   int  m_rem;
   bit  m_err;
   bit  m_bits[$];

   always @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         m_phase = 0; m_rem = 0; m_err = 0; m_bits.delete();
      end else if (i_Abort) begin
         m_phase = 0; m_bits.delete();
      end else if (i_Start) begin
         m_bits.delete(); m_err = 0;
         if (i_Len == 0) begin m_phase = 2; m_rem = W; end
         else begin m_phase = 1; m_rem = int'(i_Len); end
      end else if ((m_phase == 1 || m_phase == 2) && i_Bit_Valid && !i_Bit_Stuffed) begin
         m_bits.push_back(i_Bit);
         m_rem--;
         if (m_rem == 0) begin
            if (m_phase == 1) begin m_phase = 2; m_rem = W; end
            else begin m_phase = 3; m_err = (crc_of(m_bits) != 0); end
         end
      end else if (m_phase == 3) begin
         m_phase = 0;
      end
   end

   always @(negedge i_Clk) begin
      if (!i_Rst) begin
         chk("model_crc", 32'(o_CRC), 32'(crc_of(m_bits)));
         chk("model_busy", 32'(o_Busy), 32'(m_phase == 1 || m_phase == 2));
         chk("model_in_crc", 32'(o_In_CRC), 32'(m_phase == 2));
         chk("model_done", 32'(o_Done), 32'(m_phase == 3));
         chk("model_err", 32'(o_CRC_Err), 32'(m_err));
         if (o_Done) done_seen++;
      end
   end

   task automatic tick();
      @(negedge i_Clk);
   endtask

   task automatic start(input logic [6:0] len);
      i_Start = 1'b1; i_Len = len;
      tick();
      i_Start = 1'b0;
   endtask

   task automatic send(input logic b, input logic stuffed);
      i_Bit_Valid = 1'b1; i_Bit = b; i_Bit_Stuffed = stuffed;
      tick();
      i_Bit_Valid = 1'b0; i_Bit_Stuffed = 1'b0;
   endtask

   task automatic send_crc(input logic [14:0] v, input logic flip_last);
      for (int i = 14; i >= 0; i--) send((i == 0) ? (v[i] ^ flip_last) : v[i], 1'b0);
   endtask

   int d0;

   initial begin
      tick(); tick();
      chk("rst_crc", 32'(o_CRC), 32'h0);
      chk("rst_busy", 32'(o_Busy), 32'h0);
      chk("rst_done", 32'(o_Done), 32'h0);
      chk("rst_err", 32'(o_CRC_Err), 32'h0);
      i_Rst = 1'b0;
      tick();
      send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b0, 1'b0);
      chk("idle_bits_crc", 32'(o_CRC), 32'h0);
      chk("idle_busy", 32'(o_Busy), 32'h0);

      // len 1, data bit 1, then the matching CRC field
      start(7'd1);
      chk("start_busy", 32'(o_Busy), 32'h1);
      send(1'b1, 1'b0);
      chk("one_bit_crc", 32'(o_CRC), 32'h4599);
      chk("one_bit_in_crc", 32'(o_In_CRC), 32'h1);
      d0 = done_seen;
      send_crc(15'h4599, 1'b0);
      chk("good_done", 32'(o_Done), 32'h1);
      chk("good_err", 32'(o_CRC_Err), 32'h0);
      chk("good_residue", 32'(o_CRC), 32'h0);
      tick(); tick();
      chk("good_done_once", 32'(done_seen - d0), 32'h1);
      chk("good_idle_busy", 32'(o_Busy), 32'h0);

      // same frame, last CRC bit inverted; restart during the DONE cycle
      start(7'd1);
      send(1'b1, 1'b0);
      send_crc(15'h4599, 1'b1);
      chk("bad_done", 32'(o_Done), 32'h1);
      chk("bad_err", 32'(o_CRC_Err), 32'h1);
      chk("bad_residue", 32'(o_CRC), 32'h4599);
      start(7'd3);
      chk("start_in_done_clears_err", 32'(o_CRC_Err), 32'h0);
      chk("start_in_done_busy", 32'(o_Busy), 32'h1);

      // 1,0,1 with stuffed bits between
      send(1'b1, 1'b0); send(1'b1, 1'b1); send(1'b0, 1'b0); send(1'b1, 1'b1);
      chk("stuff_still_data", 32'(o_In_CRC), 32'h0);
      send(1'b1, 1'b0);
      chk("stuff_crc", 32'(o_CRC), 32'h1D56);
      chk("stuff_in_crc", 32'(o_In_CRC), 32'h1);
      send(1'b0, 1'b0); send(1'b1, 1'b0);

      // abort mid-DATA
      start(7'd5);
      send(1'b1, 1'b0); send(1'b1, 1'b0);
      d0 = done_seen;
      i_Abort = 1'b1; tick(); i_Abort = 1'b0;
      chk("abort_crc", 32'(o_CRC), 32'h0);
      chk("abort_busy", 32'(o_Busy), 32'h0);
      tick(); tick();
      chk("abort_no_done", 32'(done_seen - d0), 32'h0);

      // start together with a valid bit: bit dropped, count from i_Len
      i_Start = 1'b1; i_Len = 7'd2; i_Bit_Valid = 1'b1; i_Bit = 1'b1;
      tick();
      i_Start = 1'b0; i_Bit_Valid = 1'b0;
      chk("start_bit_dropped", 32'(o_CRC), 32'h0);
      send(1'b1, 1'b0);
      chk("start_cnt_data", 32'(o_In_CRC), 32'h0);
      send(1'b0, 1'b0);
      chk("start_cnt_crc", 32'(o_In_CRC), 32'h1);
      send(1'b1, 1'b0);
      start(7'd4);
      chk("restart_mid_crc", 32'(o_CRC), 32'h0);
      chk("restart_mid_in_crc", 32'(o_In_CRC), 32'h0);

      // zero-length frame
      start(7'd0);
      chk("len0_in_crc", 32'(o_In_CRC), 32'h1);
      for (int i = 0; i < 15; i++) send(1'b0, 1'b0);
      chk("len0_done", 32'(o_Done), 32'h1);
      chk("len0_err", 32'(o_CRC_Err), 32'h0);

      // async reset mid-CRC
      start(7'd0);
      for (int i = 0; i < 5; i++) send(1'b1, 1'b0);
      chk("pre_rst_busy", 32'(o_Busy), 32'h1);
      i_Rst = 1'b1;
      #1;
      chk("arst_crc", 32'(o_CRC), 32'h0);
      chk("arst_busy", 32'(o_Busy), 32'h0);
      chk("arst_in_crc", 32'(o_In_CRC), 32'h0);
      chk("arst_done", 32'(o_Done), 32'h0);
      chk("arst_err", 32'(o_CRC_Err), 32'h0);
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
